// File: rtl/crc_engine.sv
// Parameterised non-reflected CRC generator/checker with multi-bit folding per cycle
// and MSB-first serial emission of the register contents.
module crc_engine #(
  parameter int unsigned CRC_W  = 16,
  parameter int unsigned DATA_W = 1,
  parameter logic [31:0] POLY   = 32'h0000_8005,
  parameter logic [31:0] INIT   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              crc_en,
  input  logic              crc_clr,
  input  logic              shift_out,
  output logic [CRC_W-1:0]  crc_out,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              busy,
  output logic              crc_ok
);

  localparam int unsigned CNT_W = (CRC_W > 1) ? $clog2(CRC_W) : 1;
  localparam logic [CRC_W-1:0] PolyW = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] InitW = INIT[CRC_W-1:0];
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(CRC_W - 1);

  typedef enum logic [0:0] {StRun, StShift} state_e;

  state_e             r_state;
  state_e             w_state_d;
  logic [CRC_W-1:0]   r_crc;
  logic [CRC_W-1:0]   w_crc_d;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_d;
  logic [CRC_W-1:0]   w_crc_fold;

  // Unrolled bit-serial update: data_in[DATA_W-1] enters the register first.
  function automatic logic [CRC_W-1:0] fold_word(input logic [CRC_W-1:0] crc_in,
                                                 input logic [DATA_W-1:0] word);
    logic [CRC_W-1:0] acc;
    logic             fb;
    acc = crc_in;
    for (int i = 0; i < DATA_W; i++) begin
      fb  = acc[CRC_W-1] ^ word[DATA_W-1-i];
      acc = {acc[CRC_W-2:0], 1'b0} ^ (fb ? PolyW : '0);
    end
    return acc;
  endfunction

  assign w_crc_fold = fold_word(r_crc, data_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StRun;
      r_crc   <= InitW;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_crc   <= w_crc_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_crc_d   = r_crc;
    w_cnt_d   = r_cnt;
    if (crc_clr) begin
      w_state_d = StRun;
      w_crc_d   = InitW;
      w_cnt_d   = '0;
    end else begin
      unique case (r_state)
        StRun: begin
          // Absorb first so a simultaneous shift_out emits the updated register.
          if (crc_en) begin
            w_crc_d = w_crc_fold;
          end
          if (shift_out) begin
            w_state_d = StShift;
            w_cnt_d   = CntLast;
          end
        end
        StShift: begin
          w_crc_d = {r_crc[CRC_W-2:0], 1'b0};
          w_cnt_d = r_cnt - 1'b1;
          if (r_cnt == '0) begin
            w_state_d = StRun;
          end
        end
        default: begin
          w_state_d = StRun;
        end
      endcase
    end
  end

  always_comb begin
    ser_valid = (r_state == StShift);
    busy      = (r_state == StShift);
    ser_out   = (r_state == StShift) & r_crc[CRC_W-1];
    crc_out   = r_crc;
    crc_ok    = (r_crc == '0);
  end

endmodule

// File: tb/tb_crc_engine.sv
// Self-checking bench for crc_engine: byte-wide and bit-serial instances checked
// against a polynomial long-division reference model.
module tb_crc_engine;

  typedef bit bitq_t[$];

  logic        clk;
  logic        rst;

  logic [7:0]  d8_data;
  logic        d8_en, d8_clr, d8_shift;
  logic [15:0] d8_crc;
  logic        d8_ser, d8_valid, d8_busy, d8_ok;

  logic [0:0]  d1_data;
  logic        d1_en, d1_clr, d1_shift;
  logic [15:0] d1_crc;
  logic        d1_ser, d1_valid, d1_busy, d1_ok;

  int          n_checks;
  int          n_errors;
  logic [15:0] exp8;
  logic [15:0] exp1;
  logic [7:0]  check_str [9];

  crc_engine #(.CRC_W(16), .DATA_W(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .data_in   (d8_data),
    .crc_en    (d8_en),
    .crc_clr   (d8_clr),
    .shift_out (d8_shift),
    .crc_out   (d8_crc),
    .ser_out   (d8_ser),
    .ser_valid (d8_valid),
    .busy      (d8_busy),
    .crc_ok    (d8_ok)
  );

  crc_engine #(.CRC_W(16), .DATA_W(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .data_in   (d1_data),
    .crc_en    (d1_en),
    .crc_clr   (d1_clr),
    .shift_out (d1_shift),
    .crc_out   (d1_crc),
    .ser_out   (d1_ser),
    .ser_valid (d1_valid),
    .busy      (d1_busy),
    .crc_ok    (d1_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Remainder of (crc * x^n + M(x) * x^16) mod G(x) by textbook long division.
  function automatic logic [15:0] model_crc(input logic [15:0] crc, input bitq_t m);
    bit          dv[$];
    logic [16:0] gen;
    logic [15:0] rem;
    int          n;
    gen = 17'h1_8005;
    n   = m.size();
    for (int k = 0; k < n + 16; k++) begin
      dv.push_back(((k < 16) ? crc[15-k] : 1'b0) ^ ((k < n) ? m[k] : 1'b0));
    end
    for (int k = 0; k < n; k++) begin
      if (dv[k]) begin
        for (int j = 0; j <= 16; j++) dv[k+j] = dv[k+j] ^ gen[16-j];
      end
    end
    for (int k = 0; k < 16; k++) rem[15-k] = dv[n+k];
    return rem;
  endfunction

  function automatic bitq_t word_bits(input logic [31:0] v, input int w);
    bitq_t q;
    for (int i = w - 1; i >= 0; i--) q.push_back(v[i]);
    return q;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send8(input logic [7:0] b);
    d8_data = b;
    d8_en   = 1'b1;
    tick();
    d8_en   = 1'b0;
    exp8    = model_crc(exp8, word_bits({24'h0, b}, 8));
  endtask

  task automatic send1(input bit b);
    d1_data = b;
    d1_en   = 1'b1;
    tick();
    d1_en   = 1'b0;
    exp1    = model_crc(exp1, word_bits({31'h0, b}, 1));
  endtask

  task automatic clr8();
    d8_clr = 1'b1;
    tick();
    d8_clr = 1'b0;
    exp8   = 16'h0000;
  endtask

  task automatic send_str8();
    foreach (check_str[i]) send8(check_str[i]);
  endtask

  // Emit the register serially; optionally absorb a byte on the start edge.
  task automatic shift8(input string tag, input bit with_en, input logic [7:0] b);
    if (with_en) begin
      d8_data = b;
      d8_en   = 1'b1;
      exp8    = model_crc(exp8, word_bits({24'h0, b}, 8));
    end
    d8_shift = 1'b1;
    tick();
    d8_shift = 1'b0;
    d8_en    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_valid"}, 32'(d8_valid), 32'h1);
      chk({tag, "_busy"}, 32'(d8_busy), 32'h1);
      chk({tag, "_bit"}, 32'(d8_ser), 32'(exp8[15-i]));
      tick();
    end
    exp8 = 16'h0000;
    chk({tag, "_done_valid"}, 32'(d8_valid), 32'h0);
    chk({tag, "_done_busy"}, 32'(d8_busy), 32'h0);
    chk({tag, "_done_crc"}, 32'(d8_crc), 32'h0);
    chk({tag, "_done_ok"}, 32'(d8_ok), 32'h1);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    check_str = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    exp8 = 16'h0000;
    exp1 = 16'h0000;
    d8_data = '0; d8_en = 0; d8_clr = 0; d8_shift = 0;
    d1_data = '0; d1_en = 0; d1_clr = 0; d1_shift = 0;
    rst = 1'b1;
    #1;
    chk("rst_crc8", 32'(d8_crc), 32'h0);
    chk("rst_ok8", 32'(d8_ok), 32'h1);
    chk("rst_valid8", 32'(d8_valid), 32'h0);
    chk("rst_busy8", 32'(d8_busy), 32'h0);
    chk("rst_ser8", 32'(d8_ser), 32'h0);
    chk("rst_crc1", 32'(d1_crc), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Check string, byte-wide
    send_str8();
    chk("str8_const", 32'(d8_crc), 32'h0000_FEE8);
    chk("str8_model", 32'(d8_crc), 32'(exp8));

    // Same string, bit-serial
    foreach (check_str[i]) begin
      for (int j = 7; j >= 0; j--) send1(check_str[i][j]);
    end
    chk("str1_const", 32'(d1_crc), 32'h0000_FEE8);
    d1_clr = 1'b1;
    tick();
    d1_clr = 1'b0;
    exp1 = 16'h0000;
    chk("clr1", 32'(d1_crc), 32'h0);
    send1(1'b1);
    chk("bit1_const", 32'(d1_crc), 32'h0000_8005);
    chk("bit1_model", 32'(d1_crc), 32'(exp1));

    // Serial emission of 0xFEE8
    shift8("shift", 1'b0, 8'h00);

    // Good and bad residue
    clr8();
    send_str8();
    send8(8'hFE);
    send8(8'hE8);
    chk("resid_crc", 32'(d8_crc), 32'h0);
    chk("resid_ok", 32'(d8_ok), 32'h1);
    clr8();
    send_str8();
    send8(8'hFE);
    send8(8'hE9);
    chk("resid_bad_ok", 32'(d8_ok), 32'h0);
    chk("resid_bad_crc", 32'(d8_crc), 32'(exp8));

    // crc_clr aborts emission at bit 5
    clr8();
    send_str8();
    d8_shift = 1'b1;
    tick();
    d8_shift = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("abort_pre_valid", 32'(d8_valid), 32'h1);
    chk("abort_pre_bit", 32'(d8_ser), 32'(exp8[10]));
    clr8();
    chk("abort_valid", 32'(d8_valid), 32'h0);
    chk("abort_busy", 32'(d8_busy), 32'h0);
    chk("abort_crc", 32'(d8_crc), 32'h0);
    send8(8'hA5);
    chk("abort_after_en", 32'(d8_crc), 32'(exp8));

    // Asynchronous reset between edges
    send8(8'h5A);
    send8(8'hC3);
    rst = 1'b1;
    #1;
    chk("async_rst_crc", 32'(d8_crc), 32'h0);
    chk("async_rst_ok", 32'(d8_ok), 32'h1);
    #1;
    rst = 1'b0;
    exp8 = 16'h0000;
    exp1 = 16'h0000;
    tick();
    chk("post_rst_crc", 32'(d8_crc), 32'h0);

    // Reset during emission
    send8(8'h77);
    d8_shift = 1'b1;
    tick();
    d8_shift = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("shift_rst_valid", 32'(d8_valid), 32'h0);
    chk("shift_rst_ser", 32'(d8_ser), 32'h0);
    #1;
    rst = 1'b0;
    exp8 = 16'h0000;
    tick();
    chk("shift_rst_valid2", 32'(d8_valid), 32'h0);

    // crc_en together with shift_out
    send8(8'h12);
    send8(8'h34);
    shift8("enshift", 1'b1, 8'h9C);

    // Randomized absorb/clear on both instances
    exp1 = d1_crc === 16'h0000 ? 16'h0000 : exp1;
    for (int c = 0; c < 300; c++) begin
      d8_data = 8'($urandom);
      d8_en   = ($urandom_range(0, 3) != 0);
      d8_clr  = ($urandom_range(0, 19) == 0);
      d1_data = 1'($urandom);
      d1_en   = ($urandom_range(0, 3) != 0);
      d1_clr  = ($urandom_range(0, 19) == 0);
      if (d8_clr) exp8 = 16'h0000;
      else if (d8_en) exp8 = model_crc(exp8, word_bits({24'h0, d8_data}, 8));
      if (d1_clr) exp1 = 16'h0000;
      else if (d1_en) exp1 = model_crc(exp1, word_bits({31'h0, d1_data}, 1));
      tick();
      chk("rand_crc8", 32'(d8_crc), 32'(exp8));
      chk("rand_crc1", 32'(d1_crc), 32'(exp1));
      chk("rand_ok8", 32'(d8_ok), 32'(exp8 == 16'h0000));
    end
    d8_en = 0; d8_clr = 0; d1_en = 0; d1_clr = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/crc_engine.md
CRC_ENGINE -- requirements
Module: crc_engine

Interface
REQ-001 SHALL have parameter CRC_W, default 16: CRC register width, legal range 8..32.
REQ-002 SHALL have parameter DATA_W, default 1: data bits absorbed per enabled cycle, legal range 1..32.
REQ-003 SHALL have parameter POLY, default 16'h8005: generator polynomial with the implicit x^CRC_W term omitted.
REQ-004 SHALL have parameter INIT, default 0: register value loaded on reset and on crc_clr.
REQ-005 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port data_in  in  DATA_W  data word; bit DATA_W-1 is processed first.
REQ-008 SHALL have port crc_en  in  1  absorb data_in this cycle.
REQ-009 SHALL have port crc_clr  in  1  synchronous reload of INIT; aborts shift-out.
REQ-010 SHALL have port shift_out  in  1  pulse to start serial emission of the CRC register.
REQ-011 SHALL have port crc_out  out  CRC_W  current register value.
REQ-012 SHALL have port ser_out  out  1  serial CRC bit, MSB first.
REQ-013 SHALL have port ser_valid  out  1  ser_out carries a CRC bit this cycle.
REQ-014 SHALL have port busy  out  1  shift-out in progress.
REQ-015 SHALL have port crc_ok  out  1  register equals zero (good residue).

Function
REQ-016 SHALL process each data bit b in the following order: fb = crc[CRC_W-1] ^ b; crc = (crc << 1) ^ (fb ? POLY : 0). The computation is non-reflected with no final XOR.
REQ-017 SHALL fold all DATA_W bits within one cycle, so that a DATA_W-bit word gives the same result as DATA_W serial cycles carrying the same bits MSB first.
REQ-018 SHALL implement a two-state FSM with states RUN and SHIFT.
REQ-019 In RUN, SHALL apply REQ-016 on each clock edge where crc_en=1; with crc_en=0 the register holds.
REQ-020 In RUN, SHALL move to SHIFT on an edge where shift_out=1 and load the bit counter with CRC_W-1.
REQ-021 When crc_en and shift_out are both 1 in RUN, SHALL absorb the data first; the first emitted bit then comes from the updated register.
REQ-022 In SHIFT, SHALL hold ser_valid=1 and busy=1, with ser_out = crc[CRC_W-1] (combinational).
REQ-023 In SHIFT, SHALL on each edge shift the register left by 1 inserting 0 and decrement the counter.
REQ-024 In SHIFT, SHALL on the edge where the counter equals 0 return to RUN; exactly CRC_W bits are emitted and the register ends at 0.
REQ-025 In SHIFT, SHALL ignore crc_en and shift_out.
REQ-026 SHALL give crc_clr priority over all other inputs in any state: register = INIT, state = RUN, counter = 0.
REQ-027 SHALL drive crc_ok combinationally as (crc_out == 0) in every state.
REQ-028 SHALL have a combined latency of 1 clock from crc_en or crc_clr to crc_out update.

Reset
REQ-029 Asserting rst SHALL, immediately and independent of clk, set crc_out=INIT, state=RUN, counter=0, ser_valid=0, busy=0, and ser_out=0.
REQ-030 While rst is asserted, crc_ok SHALL equal (INIT==0).
REQ-031 rst asserted during SHIFT SHALL abort the emission with no further ser_valid.
REQ-032 Outputs SHALL be defined from the first edge after rst is released.

Verification
REQ-033 Bench SHALL cover: DATA_W=8, defaults, bytes "123456789" (0x31..0x39) -> crc_out=0xFEE8 one cycle after the last byte.
REQ-034 Bench SHALL cover: DATA_W=1, the same 72 bits MSB first -> crc_out=0xFEE8; a single bit 1 from INIT=0 -> 0x8005.
REQ-035 Bench SHALL cover: after "123456789", pulse shift_out -> 16 cycles of ser_valid=1 with ser_out 1111111011101000, busy=1 throughout, then RUN with crc_out=0 and crc_ok=1.
REQ-036 Bench SHALL cover: "123456789" followed by bytes 0xFE,0xE8 -> crc_out=0x0000, crc_ok=1; with 0xFE,0xE9 instead -> crc_ok=0.
REQ-037 Bench SHALL cover: crc_clr at shift bit 5 -> ser_valid=0 next cycle, crc_out=INIT, and a later crc_en accepted.
REQ-038 Bench SHALL cover: rst pulse mid-accumulation between clock edges -> crc_out=INIT before the next edge; crc_en together with shift_out -> emitted bits match the post-update register.
